// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: input synchroniser and glitch filter, an
// 11-bit frame FSM with parity/stop/timeout checking, and a small scan-code FIFO.
module ps2_frame_receiver #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 50000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       read,
  output logic [7:0] scan_code,
  output logic       scan_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow
);

  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT + 1);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic             clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic             filt_clk_q, filt_clk_d;
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
  logic             fedge;

  state_e           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic             push;
  logic             perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [7:0]       scan_code_q, scan_code_d;
  logic             pop, full, do_push;

  always_comb begin
    // Glitch filter: the level flips only on the FILTER_LEN-th consecutive differing sample.
    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    if (clk_s2_q != filt_clk_q) begin
      if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) filt_clk_d = clk_s2_q;
      else                                      filt_cnt_d = filt_cnt_q + 1'b1;
    end
    fedge = filt_clk_q & ~filt_clk_d;

    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    push      = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    tmo_d     = (state_q == StIdle || fedge) ? '0 : tmo_q + 1'b1;

    case (state_q)
      StIdle: begin
        if (fedge && !dat_s2_q) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (fedge) begin
          shift_d[bit_cnt_q] = dat_s2_q;
          bit_cnt_d          = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (fedge) begin
          par_d   = dat_s2_q;
          state_d = StStop;
        end
      end
      StStop: begin
        if (fedge) begin
          state_d = StIdle;
          if (!dat_s2_q)                 ferr_d = 1'b1;
          else if (!(^{shift_q, par_q})) perr_d = 1'b1;
          else                           push   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle && !fedge && tmo_q == TmoW'(TIMEOUT - 1)) begin
      state_d = StIdle;
      ferr_d  = 1'b1;
    end

    // FIFO; a push into a full FIFO survives only if the same cycle pops.
    pop      = read && (cnt_q != '0);
    full     = (cnt_q == CntW'(FIFO_DEPTH));
    do_push  = push && (!full || pop);
    ovf_d    = push && full && !pop;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    scan_code_d = (cnt_d != '0) ? mem_d[rd_ptr_d] : scan_code_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      filt_clk_q  <= 1'b1;
      filt_cnt_q  <= '0;
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovf_q       <= 1'b0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      scan_code_q <= '0;
    end else begin
      clk_s1_q    <= ps2_clk;
      clk_s2_q    <= clk_s1_q;
      dat_s1_q    <= ps2_dat;
      dat_s2_q    <= dat_s1_q;
      filt_clk_q  <= filt_clk_d;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovf_q       <= ovf_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      scan_code_q <= scan_code_d;
    end
  end

  assign scan_code  = scan_code_q;
  assign scan_ready = (cnt_q != '0);
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed bench for ps2_frame_receiver: PS/2 frames are bit-banged in, accepted
// bytes go to a scoreboard queue and are compared as they are read out.
module tb_ps2_frame_receiver;

  localparam int unsigned FilterLen = 8;
  localparam int unsigned Timeout   = 600;
  localparam int unsigned Depth     = 4;
  localparam int          Half      = 40;  // clk cycles per PS/2 clock phase

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       read = 1'b0;
  logic [7:0] scan_code;
  logic       scan_ready, parity_err, frame_err, overflow;

  int n_assert = 0;
  int n_fail   = 0;
  int pe_cnt = 0, fe_cnt = 0, ovf_cnt = 0;
  int pe0, fe0, ovf0;
  logic [7:0] exp_q[$];

  ps2_frame_receiver #(
    .FILTER_LEN(FilterLen),
    .TIMEOUT   (Timeout),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .read      (read),
    .scan_code (scan_code),
    .scan_ready(scan_ready),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Pulse counters; a pulse wider than one cycle counts more than once.
  always @(negedge clk) begin
    if (parity_err) pe_cnt++;
    if (frame_err)  fe_cnt++;
    if (overflow)   ovf_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic v, input logic glitch);
    ps2_dat = v;
    wait_cyc(Half / 2);
    ps2_clk = 1'b0;
    wait_cyc(Half);
    ps2_clk = 1'b1;
    if (glitch) begin
      wait_cyc(8);
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(Half / 2 - 11);
    end else begin
      wait_cyc(Half / 2);
    end
  endtask

  // Sends the first nbits bits of a frame; glitch_bit selects a bit whose high phase is glitched.
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits,
                            input int glitch_bit);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(bits[i], i == glitch_bit);
    ps2_dat = 1'b1;
    wait_cyc(4);
  endtask

  task automatic do_read(input string tag);
    logic [7:0] exp;
    @(negedge clk);
    check({tag, "_ready"}, 32'(scan_ready), 32'd1);
    if (exp_q.size() != 0) exp = exp_q.pop_front();
    else                   exp = 8'hxx;
    check({tag, "_code"}, 32'(scan_code), 32'(exp));
    @(posedge clk);
    #1 read = 1'b1;
    @(posedge clk);
    #1 read = 1'b0;
  endtask

  task automatic snap();
    pe0 = pe_cnt;
    fe0 = fe_cnt;
    ovf0 = ovf_cnt;
  endtask

  initial begin
    // Reset state
    wait_cyc(3);
    @(negedge clk);
    check("rst_ready", 32'(scan_ready), 32'd0);
    check("rst_code", 32'(scan_code), 32'h00);
    check("rst_perr", 32'(parity_err), 32'd0);
    check("rst_ferr", 32'(frame_err | overflow), 32'd0);
    #1 reset = 1'b0;
    wait_cyc(5);

    // Clean frame, pop, then empty
    send_frame(8'h1C, 1'b0, 11, -1);
    exp_q.push_back(8'h1C);
    do_read("f1c");
    @(negedge clk);
    check("f1c_empty", 32'(scan_ready), 32'd0);

    // Parity error then good frame
    snap();
    send_frame(8'h1C, 1'b1, 11, -1);
    @(negedge clk);
    check("par_pulse", 32'(pe_cnt - pe0), 32'd1);
    check("par_noferr", 32'(fe_cnt - fe0), 32'd0);
    check("par_noready", 32'(scan_ready), 32'd0);
    send_frame(8'h75, 1'b0, 11, -1);
    exp_q.push_back(8'h75);
    do_read("f75");

    // Two queued frames
    send_frame(8'hF0, 1'b0, 11, -1);
    exp_q.push_back(8'hF0);
    send_frame(8'h1C, 1'b0, 11, -1);
    exp_q.push_back(8'h1C);
    do_read("q0");
    do_read("q1");
    @(negedge clk);
    check("q_empty", 32'(scan_ready), 32'd0);

    // Overflow on the fifth frame
    snap();
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i), 1'b0, 11, -1);
      exp_q.push_back(8'(i));
    end
    check("ovf_none_at4", 32'(ovf_cnt - ovf0), 32'd0);
    send_frame(8'h05, 1'b0, 11, -1);
    @(negedge clk);
    check("ovf_pulse", 32'(ovf_cnt - ovf0), 32'd1);
    for (int i = 0; i < 4; i++) do_read("ovf_rd");
    @(negedge clk);
    check("ovf_empty", 32'(scan_ready), 32'd0);

    // Timeout: start + 5 data bits, then silence
    snap();
    send_frame(8'h5A, 1'b0, 6, -1);
    wait_cyc(Timeout + 10);
    @(negedge clk);
    check("tmo_ferr", 32'(fe_cnt - fe0), 32'd1);
    check("tmo_noready", 32'(scan_ready), 32'd0);
    send_frame(8'h5A, 1'b0, 11, -1);
    exp_q.push_back(8'h5A);
    do_read("tmo_next");

    // Short clock glitch mid-frame is filtered out
    snap();
    send_frame(8'hA3, 1'b0, 11, 4);
    exp_q.push_back(8'hA3);
    do_read("glitch");
    check("glitch_noerr", 32'(pe_cnt - pe0 + fe_cnt - fe0), 32'd0);

    // Reset mid-frame with a byte still queued
    send_frame(8'h33, 1'b0, 11, -1);
    send_frame(8'h99, 1'b0, 4, -1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", 32'(scan_ready), 32'd0);
    check("mid_rst_code", 32'(scan_code), 32'h00);
    #1 reset = 1'b0;
    wait_cyc(5);
    send_frame(8'hC6, 1'b0, 11, -1);
    exp_q.push_back(8'hC6);
    do_read("post_rst");

    // Totals over the whole run
    @(negedge clk);
    check("tot_perr", 32'(pe_cnt), 32'd1);
    check("tot_ferr", 32'(fe_cnt), 32'd1);
    check("tot_ovf", 32'(ovf_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_frame_receiver.md
Name: ps2_frame_receiver

Overview:
- Upstream stage of the keyboard decode path. Deserialises raw PS/2 device-to-host frames (ps2_clk/ps2_dat) into 8-bit scan codes.
- Buffers the scan codes in a small FIFO and presents them with a scan_ready/read handshake.
- The scan-history/key-decode logic consumes its output; its read input is driven by a one-cycle oneshot pulse derived from scan_ready.
- Replaces the opaque vendor receiver with one that has glitch filtering, parity checking, frame timeout and overflow reporting.

Parameters:
- FILTER_LEN, 8: consecutive identical clk samples required before the filtered ps2_clk changes level.
- TIMEOUT, 50000: clk cycles allowed between successive ps2_clk falling edges inside a frame (1 ms at 50 MHz).
- FIFO_DEPTH, 4: scan-code buffer entries; power of two, at least 2.

Ports:
- clk  input  1  system clock (50 MHz).
- reset  input  1  asynchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock from the connector, asynchronous.
- ps2_dat  input  1  raw PS/2 data from the connector, asynchronous.
- read  input  1  pop request; each clk cycle it is high while scan_ready=1 pops one entry.
- scan_code  output  8  FIFO head entry.
- scan_ready  output  1  high while FIFO is non-empty.
- parity_err  output  1  one-cycle pulse when a frame fails the odd-parity check.
- frame_err  output  1  one-cycle pulse on a bad stop bit or a timeout abort.
- overflow  output  1  one-cycle pulse when a valid frame is dropped because the FIFO is full.

Behaviour:
- Reset (async, active-high):
  - FSM to IDLE; FIFO emptied; FIFO storage cleared.
  - scan_code=8'h00, scan_ready=0, all error pulses 0.
  - Filtered clock set to 1; timeout counter cleared.
  - Reset mid-frame discards the partial frame.
- Input conditioning:
  - ps2_clk and ps2_dat each pass through a 2-FF synchroniser.
  - Filtered clock takes the synchronised level only after FILTER_LEN consecutive equal samples; shorter glitches are ignored.
  - Falling edge of the filtered clock = "fedge", a one-cycle strobe. Synchronised ps2_dat is sampled on the fedge cycle.
- Frame = start(0), D0..D7 LSB-first, odd parity, stop(1). FSM:
  - IDLE: fedge with dat=0 -> DATA, bit count 0. fedge with dat=1 -> stay (spurious edge, no error).
  - DATA: on each fedge, shift dat into bit[count], count+1; after the 8th bit -> PARITY.
  - PARITY: on fedge, latch the parity bit -> STOP.
  - STOP: on fedge -> IDLE, with this priority:
    - dat=0: frame_err pulse, discard.
    - parity wrong (XOR of the 8 data bits plus parity bit must be 1): parity_err pulse, discard.
    - otherwise push the byte.
- Timeout:
  - Counter clears on every fedge and in IDLE; increments otherwise.
  - Outside IDLE, reaching TIMEOUT -> IDLE, frame_err pulse, partial data discarded.
- FIFO:
  - Push occurs on the clk edge that processes the stop-bit fedge. scan_ready is high and scan_code valid on the next cycle.
  - scan_code = entry at the read pointer. When empty, it shows the last popped (or reset) value; consumers must gate on scan_ready.
  - read while empty is ignored.
  - Push while full and no pop in the same cycle: byte dropped, overflow pulse, FIFO contents unchanged.
  - Push and pop in the same cycle: both performed, occupancy unchanged, including when full (no overflow).
  - Pointers wrap modulo FIFO_DEPTH; occupancy is counted 0..FIFO_DEPTH.
- All error pulses last exactly one clk cycle and are mutually exclusive per frame.

Test Plan:
- Clean frame 0x1C (parity 0), 10 kHz PS/2 clock -> one cycle after the stop edge: scan_ready=1, scan_code=8'h1C. One-cycle read pulse -> scan_ready=0 next cycle.
- Frame 0x1C with parity bit 1 -> parity_err pulses once; scan_ready stays 0. Following good frame 0x75 -> scan_code=8'h75.
- Frames F0 then 1C with no reads -> first entry 8'hF0. read -> 8'h1C. read -> scan_ready=0.
- Five good frames 0x01..0x05, no reads (FIFO_DEPTH=4) -> overflow pulses on the 5th. Four reads return 01,02,03,04.
- Start bit plus 5 data bits, then clock idle for TIMEOUT+10 cycles -> frame_err pulses, no push. Next full frame 0x5A -> received correctly.
- Glitch: ps2_clk low for 3 clk cycles mid-frame -> ignored, frame decodes correctly. Assert reset mid-frame -> outputs at reset values; next frame decodes correctly.
